// File: rtl/crt_pkg.sv
// crt_pkg: register indices, field widths and class masks for the CRTC register file
package crt_pkg;
  localparam int DATA_W = 8;
  localparam int NREGS = 16;
  localparam int R_HTOTAL = 0, R_HDISP = 1, R_HSYNC = 2, R_SYNCW = 3;
  localparam int R_VTOTAL = 4, R_VADJ = 5, R_VDISP = 6, R_VSYNC = 7;
  localparam int R_MODE = 8, R_MAXSCAN = 9, R_CURSTART = 10, R_CUREND = 11;
  localparam int R_STARTHI = 12, R_STARTLO = 13, R_CURHI = 14, R_CURLO = 15;
  localparam int W_HTOTAL = 8, W_HDISP = 8, W_HSYNC = 8, W_SYNCW = 8;
  localparam int W_VTOTAL = 7, W_VADJ = 5, W_VDISP = 7, W_VSYNC = 7;
  localparam int W_MODE = 2, W_MAXSCAN = 5, W_CURSTART = 7, W_CUREND = 5;
  localparam int W_STARTHI = 6, W_STARTLO = 8, W_CURHI = 6, W_CURLO = 8;
  localparam int REG_W [NREGS] = '{W_HTOTAL, W_HDISP, W_HSYNC, W_SYNCW, W_VTOTAL, W_VADJ,
                                  W_VDISP, W_VSYNC, W_MODE, W_MAXSCAN, W_CURSTART, W_CUREND,
                                  W_STARTHI, W_STARTLO, W_CURHI, W_CURLO};
  localparam logic [NREGS-1:0] STAGED_MASK = 16'h33FF;
  localparam logic [NREGS-1:0] READABLE_MASK = 16'hF000;
  function automatic logic is_one_hot(input logic [NREGS-1:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction
  function automatic logic [DATA_W-1:0] width_mask(input int w);
    return DATA_W'((9'd1 << w) - 9'd1);
  endfunction
endpackage

// File: rtl/crt_edge_detect.sv
// crt_edge_detect: registered rising-edge detector; a level held high through reset never fires
module crt_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);
  logic prev_q, prev_d, armed_q, armed_d;
  always_comb begin
    prev_d = in;
    armed_d = armed_q | ~in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      armed_q <= armed_d;
    end
  end
  assign pulse = in & ~prev_q & armed_q;
endmodule

// File: rtl/crt_register_file.sv
// crt_register_file: CRTC R0-R15 with edge-qualified host access and frame-boundary commit
module crt_register_file
  import crt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REGS-1:0]   sel,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  frame_end,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  commit_pending,
  output logic                  sel_err,
  output logic [7:0]            h_total,
  output logic [7:0]            h_disp,
  output logic [7:0]            h_sync_pos,
  output logic [7:0]            sync_width,
  output logic [6:0]            v_total,
  output logic [4:0]            v_adj,
  output logic [6:0]            v_disp,
  output logic [6:0]            v_sync_pos,
  output logic [1:0]            mode,
  output logic [4:0]            max_scan,
  output logic [6:0]            cur_start,
  output logic [4:0]            cur_end,
  output logic [13:0]           start_addr,
  output logic [13:0]           cur_addr
);
  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS], shadow_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] active_q [NUM_REGS], active_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] dout_q, dout_d, rd_data;
  logic rd_valid_q, rd_valid_d, pending_q, pending_d, sel_err_q, sel_err_d;
  logic wr_ev, rd_ev, one_hot, staged_wr;
  crt_edge_detect u_wr_edge (.clk(clk), .rst(rst), .in(wr), .pulse(wr_ev));
  crt_edge_detect u_rd_edge (.clk(clk), .rst(rst), .in(rd), .pulse(rd_ev));
  assign one_hot = is_one_hot(sel);
  assign staged_wr = wr_ev & one_hot & |(sel & STAGED_MASK);
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      // Staged registers commit from shadow_d so a write landing on frame_end is included
      shadow_d[i] = !STAGED_MASK[i] ? '0 :
                    (wr_ev && one_hot && sel[i]) ? din & DATA_WIDTH'(width_mask(REG_W[i])) : shadow_q[i];
      active_d[i] = STAGED_MASK[i] ? (frame_end ? shadow_d[i] : active_q[i]) :
                    (wr_ev && one_hot && sel[i]) ? din & DATA_WIDTH'(width_mask(REG_W[i])) : active_q[i];
      rd_data = rd_data | ((sel[i] && READABLE_MASK[i]) ? active_q[i] : '0);
    end
    dout_d = rd_ev ? (one_hot ? rd_data : '0) : dout_q;
    rd_valid_d = rd_ev;
    pending_d = frame_end ? 1'b0 : (pending_q | staged_wr);
    sel_err_d = sel_err_q | ((wr_ev | rd_ev) & (sel != '0) & ~one_hot);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      dout_q <= '0;
      rd_valid_q <= 1'b0;
      pending_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dout_q <= dout_d;
      rd_valid_q <= rd_valid_d;
      pending_q <= pending_d;
      sel_err_q <= sel_err_d;
    end
  end
  assign dout = dout_q;
  assign rd_valid = rd_valid_q;
  assign commit_pending = pending_q;
  assign sel_err = sel_err_q;
  assign h_total = active_q[R_HTOTAL][7:0];
  assign h_disp = active_q[R_HDISP][7:0];
  assign h_sync_pos = active_q[R_HSYNC][7:0];
  assign sync_width = active_q[R_SYNCW][7:0];
  assign v_total = active_q[R_VTOTAL][6:0];
  assign v_adj = active_q[R_VADJ][4:0];
  assign v_disp = active_q[R_VDISP][6:0];
  assign v_sync_pos = active_q[R_VSYNC][6:0];
  assign mode = active_q[R_MODE][1:0];
  assign max_scan = active_q[R_MAXSCAN][4:0];
  assign cur_start = active_q[R_CURSTART][6:0];
  assign cur_end = active_q[R_CUREND][4:0];
  assign start_addr = {active_q[R_STARTHI][5:0], active_q[R_STARTLO][7:0]};
  assign cur_addr = {active_q[R_CURHI][5:0], active_q[R_CURLO][7:0]};
endmodule

// File: tb/tb_crt_register_file.sv
// tb_crt_register_file: randomized scoreboard bench against a behavioural register-file model
module tb_crt_register_file;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, frame_end = 1'b0;
  logic [15:0] sel = '0;
  logic [7:0] din = '0, dout, h_total, h_disp, h_sync_pos, sync_width;
  logic rd_valid, commit_pending, sel_err;
  logic [6:0] v_total, v_disp, v_sync_pos, cur_start;
  logic [4:0] v_adj, max_scan, cur_end;
  logic [1:0] mode;
  logic [13:0] start_addr, cur_addr;
  always #5 clk = ~clk;
  crt_register_file dut (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .rd(rd), .din(din), .frame_end(frame_end),
    .dout(dout), .rd_valid(rd_valid), .commit_pending(commit_pending), .sel_err(sel_err),
    .h_total(h_total), .h_disp(h_disp), .h_sync_pos(h_sync_pos), .sync_width(sync_width),
    .v_total(v_total), .v_adj(v_adj), .v_disp(v_disp), .v_sync_pos(v_sync_pos), .mode(mode),
    .max_scan(max_scan), .cur_start(cur_start), .cur_end(cur_end), .start_addr(start_addr),
    .cur_addr(cur_addr)
  );
  typedef struct {
    logic [104:0] regs;
    logic pend, err, rv;
    logic [7:0] dout;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_pass = 0, n_total = 0;
  // Reference model: register contents as plain arrays, strobe edges from previous drive levels
  int widths [16] = '{8, 8, 8, 8, 7, 5, 7, 7, 2, 5, 7, 5, 6, 8, 6, 8};
  logic [7:0] m_sh [16], m_ac [16];
  logic m_pend, m_err, m_prev_wr, m_prev_rd, m_arm_wr, m_arm_rd;
  logic [7:0] m_dout;
  function automatic logic is_staged(input int i);
    return (i <= 9) || (i == 12) || (i == 13);
  endfunction
  function automatic logic [104:0] model_regs();
    return {m_ac[0], m_ac[1], m_ac[2], m_ac[3], m_ac[4][6:0], m_ac[5][4:0], m_ac[6][6:0],
            m_ac[7][6:0], m_ac[8][1:0], m_ac[9][4:0], m_ac[10][6:0], m_ac[11][4:0],
            m_ac[12][5:0], m_ac[13], m_ac[14][5:0], m_ac[15]};
  endfunction
  task automatic chk(input string name, input logic [104:0] got, input logic [104:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
  endtask
  task automatic step(input logic r, input logic [15:0] s, input logic w, input logic rr,
                      input logic [7:0] d, input logic fe);
    exp_t x;
    logic wev, rev;
    int idx, cnt;
    @(negedge clk);
    rst = r; sel = s; wr = w; rd = rr; din = d; frame_end = fe;
    cnt = $countones(s);
    idx = 0;
    for (int i = 0; i < 16; i++) if (s[i]) idx = i;
    if (r) begin
      for (int i = 0; i < 16; i++) begin m_sh[i] = 0; m_ac[i] = 0; end
      m_pend = 0; m_err = 0; m_dout = 0;
      m_prev_wr = 0; m_prev_rd = 0; m_arm_wr = 0; m_arm_rd = 0;
      rev = 0;
    end else begin
      wev = w && !m_prev_wr && m_arm_wr;
      rev = rr && !m_prev_rd && m_arm_rd;
      m_arm_wr = m_arm_wr || !w; m_arm_rd = m_arm_rd || !rr;
      m_prev_wr = w; m_prev_rd = rr;
      if ((wev || rev) && cnt > 1) m_err = 1;
      if (rev) m_dout = (cnt == 1 && idx >= 12) ? m_ac[idx] : 8'h00;
      if (wev && cnt == 1) begin
        if (is_staged(idx)) begin m_sh[idx] = d % (1 << widths[idx]); m_pend = 1; end
        else m_ac[idx] = d % (1 << widths[idx]);
      end
      if (fe) begin
        for (int i = 0; i < 16; i++) if (is_staged(i)) m_ac[i] = m_sh[i];
        m_pend = 0;
      end
    end
    x.regs = model_regs(); x.pend = m_pend; x.err = m_err; x.rv = rev; x.dout = m_dout;
    exp_q.push_back(x);
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("regs", {h_total, h_disp, h_sync_pos, sync_width, v_total, v_adj, v_disp, v_sync_pos,
                   mode, max_scan, cur_start, cur_end, start_addr, cur_addr}, e.regs);
      chk("commit_pending", 105'(commit_pending), 105'(e.pend));
      chk("sel_err", 105'(sel_err), 105'(e.err));
      chk("rd_valid", 105'(rd_valid), 105'(e.rv));
      chk("dout", 105'(dout), 105'(e.dout));
    end
  end
  initial begin
    logic [15:0] rs;
    int wait_cnt;
    step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    step(0, 16'h0001, 1, 0, 8'h63, 0); step(0, 16'h0001, 0, 0, 8'h63, 0);
    step(0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 16'h8000, 1, 0, 8'hA5, 0);
    step(0, 16'h8000, 0, 0, 8'hA5, 0);
    step(0, 16'h4000, 1, 0, 8'hFF, 0); step(0, 16'h4000, 0, 0, 8'hFF, 0);
    step(0, 16'h1000, 1, 0, 8'h3F, 1); step(0, 16'h1000, 0, 0, 8'h3F, 0);
    step(0, 16'h1000, 0, 1, 0, 0); step(0, 16'h1000, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    step(0, 16'h0001, 0, 1, 0, 0); step(0, 16'h0001, 0, 0, 0, 0);
    step(0, 16'h0003, 1, 0, 8'h55, 0); step(0, 16'h0003, 0, 0, 8'h55, 0);
    step(0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 0);
    step(0, 16'h0010, 1, 0, 8'hFF, 0); step(0, 16'h0010, 1, 1, 8'hFF, 0);
    step(1, 16'h0010, 1, 1, 8'hFF, 0); step(0, 16'h0010, 1, 1, 8'hFF, 0);
    step(0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      rs = ($urandom_range(0, 9) < 2) ? 16'h0 : 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 49) == 0) rs = 16'($urandom) | 16'h0101;
      step($urandom_range(0, 199) == 0, rs, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           8'($urandom), $urandom_range(0, 19) == 0);
    end
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin @(posedge clk); #2; wait_cnt++; end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain got=%0d pending expectations want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
